// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Counter must reach WIDTH-1 without wrapping; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      if (w <= 2) begin
         return 1;
      end
      return $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One full-adder bit built from a pair of half-adder cells plus an OR.
// Ports: a, b - operand bits; cin - carry in; s - sum bit; cout - carry out.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (cin),
      .s (s),
      .c (c1)
   );

   // The two partial carries can never both be set, so OR yields the majority.
   assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half-adder cell.
// Ports: a, b - addend bits; s - sum bit (a^b); c - carry bit (a&b).
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   start      - request a new addition (sampled only when idle)
//   A, B       - operands, captured on the accepting edge
//   busy       - addition in progress
//   done       - one-cycle completion pulse
//   sum, carry - registered result {carry,sum} = A + B
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic [WIDTH-1:0]   a_sr_nxt;
   logic [WIDTH-1:0]   b_sr_nxt;
   logic [WIDTH-1:0]   res_sr_nxt;
   logic [WIDTH-1:0]   sum_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               carry_ff;
   logic               carry_ff_nxt;
   logic               carry_nxt;
   logic               busy_nxt;
   logic               done_nxt;
   logic               bit_s;
   logic               bit_c;
   logic               last_bit;

   // The single arithmetic element: adds the current LSBs and the saved carry.
   full_adder_bit u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_ff),
      .s    (bit_s),
      .cout (bit_c)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start)    state_nxt = ST_RUN;
         ST_RUN:  if (last_bit) state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      a_sr_nxt     = a_sr;
      b_sr_nxt     = b_sr;
      res_sr_nxt   = res_sr;
      carry_ff_nxt = carry_ff;
      cnt_nxt      = cnt;
      sum_nxt      = sum;
      carry_nxt    = carry;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               a_sr_nxt     = A;
               b_sr_nxt     = B;
               carry_ff_nxt = 1'b0;
               cnt_nxt      = '0;
               busy_nxt     = 1'b1;
            end
         end
         ST_RUN: begin
            res_sr_nxt   = {bit_s, res_sr[WIDTH-1:1]};
            a_sr_nxt     = {1'b0, a_sr[WIDTH-1:1]};
            b_sr_nxt     = {1'b0, b_sr[WIDTH-1:1]};
            carry_ff_nxt = bit_c;
            cnt_nxt      = cnt + CNT_W'(1);
            if (last_bit) begin
               sum_nxt   = {bit_s, res_sr[WIDTH-1:1]};
               carry_nxt = bit_c;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         carry_ff <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         a_sr     <= a_sr_nxt;
         b_sr     <= b_sr_nxt;
         res_sr   <= res_sr_nxt;
         carry_ff <= carry_ff_nxt;
         cnt      <= cnt_nxt;
         sum      <= sum_nxt;
         carry    <= carry_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

endmodule
